// File: rtl/app_sched_pkg.sv
// app_sched_pkg: shared types and packet layout for the application scheduler.
//   - sched_state_e : scheduler FSM state encoding
//   - DEF_*          : default field widths
//   - PKT_*          : packet field offsets for the default widths
//   - pkt_*() helpers: the same offsets for arbitrary parameterisations
package app_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_NEXT      = 3'd5
  } sched_state_e;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_CYC_WIDTH  = 14;

  // Packet layout: {op, addr, data}; op=0 read, op=1 write.
  localparam int PKT_DATA_LSB = 0;
  localparam int PKT_ADDR_LSB = DEF_DATA_WIDTH;
  localparam int PKT_OP_BIT   = DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

  function automatic int pkt_addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int pkt_op_bit(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

endpackage

// File: rtl/sched_countdown.sv
// sched_countdown: compute-phase cycle counter.
//   clk, rst      : clock, asynchronous active-low reset
//   load, load_val: load the counter (load_val is already clamped to >= 1)
//   dec           : decrement by one (saturates at zero)
//   last          : counter currently holds 1, i.e. this is the final compute cycle
module sched_countdown
  import app_sched_pkg::*;
#(
  parameter int CYC_WIDTH = DEF_CYC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CYC_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 last
);

  logic [CYC_WIDTH-1:0] cnt_r;

  // Countdown register: load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CYC_WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CYC_WIDTH{1'b0}})) begin
      cnt_r <= cnt_r - {{(CYC_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == {{(CYC_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/app_scheduler.sv
// app_scheduler: round-robin sequencer for NUM_APPS application instances.
// Each app in turn is strobed (RUN), given max(cycles,1) compute cycles, and
// then its request packet is issued on the network channel. Reads wait for a
// response, which is broadcast on app_result; writes complete on handshake.
//   clk, rst                    : clock, asynchronous active-low reset
//   enable                      : scheduling permitted (sampled in IDLE/NEXT)
//   app_runnable                : one-hot run strobe, one cycle per visit
//   app_request_bus             : per-app packet {op, addr, data}, slice k = app k
//   app_cycles_bus              : per-app compute cycle count, slice k = app k
//   app_result                  : last read response
//   net_req/_valid/_ready       : network request channel
//   net_resp/_valid             : network response, no backpressure
//   cur_app, busy, stray_resp   : status (stray_resp is sticky until reset)
module app_scheduler
  import app_sched_pkg::*;
#(
  parameter int NUM_APPS   = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CYC_WIDTH  = DEF_CYC_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       enable,
  output logic [NUM_APPS-1:0]                        app_runnable,
  input  logic [NUM_APPS*(ADDR_WIDTH+DATA_WIDTH+1)-1:0] app_request_bus,
  input  logic [NUM_APPS*CYC_WIDTH-1:0]              app_cycles_bus,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]             app_result,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]             net_req,
  output logic                                       net_req_valid,
  input  logic                                       net_req_ready,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]             net_resp,
  input  logic                                       net_resp_valid,
  output logic [$clog2(NUM_APPS)-1:0]                cur_app,
  output logic                                       busy,
  output logic                                       stray_resp
);

  localparam int W      = ADDR_WIDTH + DATA_WIDTH;
  localparam int AW     = $clog2(NUM_APPS);
  localparam int OP_BIT = pkt_op_bit(DATA_WIDTH, ADDR_WIDTH);

  sched_state_e          state_r, state_nxt_s;
  logic [AW-1:0]         cur_app_r, cur_app_nxt_s;
  logic [NUM_APPS-1:0]   runnable_r, runnable_nxt_s;
  logic                  net_req_valid_r;
  logic                  busy_r;
  logic                  stray_r;
  logic [W:0]            req_r;
  logic [W:0]            result_r;
  logic [W:0]            req_sel_s;
  logic [CYC_WIDTH-1:0]  cyc_sel_s;
  logic [CYC_WIDTH-1:0]  cyc_load_s;
  logic                  cnt_load_s, cnt_dec_s, cnt_last_s, capture_s;

  assign req_sel_s  = app_request_bus[int'(cur_app_r)*(W+1) +: (W+1)];
  assign cyc_sel_s  = app_cycles_bus[int'(cur_app_r)*CYC_WIDTH +: CYC_WIDTH];
  // A zero cycle count still yields one compute cycle.
  assign cyc_load_s = (cyc_sel_s == {CYC_WIDTH{1'b0}}) ?
                      {{(CYC_WIDTH-1){1'b0}}, 1'b1} : cyc_sel_s;

  sched_countdown #(
    .CYC_WIDTH (CYC_WIDTH)
  ) u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cyc_load_s),
    .dec      (cnt_dec_s),
    .last     (cnt_last_s)
  );

  // Next-state, countdown control, next app index and next-cycle run strobe.
  always_comb begin
    state_nxt_s    = state_r;
    cur_app_nxt_s  = cur_app_r;
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    capture_s      = 1'b0;
    runnable_nxt_s = {NUM_APPS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_load_s  = 1'b1;
        state_nxt_s = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        cnt_dec_s = 1'b1;
        if (cnt_last_s) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_COMPUTE;
        end
      end
      ST_ISSUE: begin
        if (net_req_ready) begin
          state_nxt_s = req_r[OP_BIT] ? ST_NEXT : ST_WAIT_RESP;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_RESP: begin
        if (net_resp_valid) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_WAIT_RESP;
        end
      end
      ST_NEXT: begin
        if (cur_app_r == AW'(NUM_APPS-1)) begin
          cur_app_nxt_s = {AW{1'b0}};
        end else begin
          cur_app_nxt_s = cur_app_r + AW'(1);
        end
        // enable is only honoured here and in IDLE, so a drop never aborts a visit.
        if (enable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they align with the state itself.
    for (int k = 0; k < NUM_APPS; k++) begin
      runnable_nxt_s[k] = (state_nxt_s == ST_RUN) && (cur_app_nxt_s == AW'(k));
    end
  end

  // State, app index, registered control outputs and the captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      cur_app_r       <= {AW{1'b0}};
      runnable_r      <= {NUM_APPS{1'b0}};
      net_req_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      req_r           <= {(W+1){1'b0}};
    end else begin
      state_r         <= state_nxt_s;
      cur_app_r       <= cur_app_nxt_s;
      runnable_r      <= runnable_nxt_s;
      net_req_valid_r <= (state_nxt_s == ST_ISSUE);
      busy_r          <= (state_nxt_s != ST_IDLE);
      if (capture_s) begin
        req_r <= req_sel_s;
      end else begin
        req_r <= req_r;
      end
    end
  end

  // Read response capture; the result only changes on a WAIT_RESP response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {(W+1){1'b0}};
    end else if ((state_r == ST_WAIT_RESP) && net_resp_valid) begin
      result_r <= net_resp;
    end else begin
      result_r <= result_r;
    end
  end

  // Sticky flag for responses arriving when none is expected (they are dropped).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stray_r <= 1'b0;
    end else if (net_resp_valid && (state_r != ST_WAIT_RESP)) begin
      stray_r <= 1'b1;
    end else begin
      stray_r <= stray_r;
    end
  end

  assign app_runnable  = runnable_r;
  assign net_req       = req_r;
  assign net_req_valid = net_req_valid_r;
  assign app_result    = result_r;
  assign cur_app       = cur_app_r;
  assign busy          = busy_r;
  assign stray_resp    = stray_r;

endmodule

// File: doc/app_scheduler.md
APP_SCHEDULER -- requirements
Module: app_scheduler

Interface
REQ-001 SHALL have parameter NUM_APPS, default 4, count of application instances sequenced (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 10, packet data field width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, packet address field width; W = ADDR_WIDTH+DATA_WIDTH.
REQ-004 SHALL have parameter CYC_WIDTH, default 14, compute-cycle field width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  scheduling permitted.
REQ-008 SHALL have port app_runnable  out  NUM_APPS  one-hot run strobe per app.
REQ-009 SHALL have port app_request_bus  in  NUM_APPS*(W+1)  app k packet at slice k; bit W op (0 read, 1 write), [W-1:DATA_WIDTH] addr, [DATA_WIDTH-1:0] data.
REQ-010 SHALL have port app_cycles_bus  in  NUM_APPS*CYC_WIDTH  app k compute cycles at slice k.
REQ-011 SHALL have port app_result  out  W+1  last read response, broadcast to all apps.
REQ-012 SHALL have port net_req / net_req_valid / net_req_ready  out W+1 / out 1 / in 1  network request channel.
REQ-013 SHALL have port net_resp / net_resp_valid  in W+1 / in 1  network response, no backpressure.
REQ-014 SHALL have ports cur_app  out  clog2(NUM_APPS)  app being served; busy  out 1  state != IDLE; stray_resp  out 1  sticky error.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, COMPUTE, ISSUE, WAIT_RESP, NEXT.
REQ-016 IDLE: app_runnable=0, net_req_valid=0; enable=1 -> RUN.
REQ-017 RUN: exactly one cycle, app_runnable[cur_app]=1 only; load countdown with max(app_cycles[cur_app],1); -> COMPUTE.
REQ-018 COMPUTE: decrement each cycle; lasts max(cycles,1) cycles; on last cycle capture app_request_bus slice cur_app into req register; -> ISSUE.
REQ-019 ISSUE: net_req_valid=1, net_req=req register, both stable until net_req_ready=1; on handshake: op=1 -> NEXT, op=0 -> WAIT_RESP.
REQ-020 WAIT_RESP: on net_resp_valid=1 capture net_resp into app_result (updates next cycle); -> NEXT. No timeout.
REQ-021 NEXT: one cycle; cur_app <= (cur_app+1) wrapping NUM_APPS-1 -> 0; enable=1 -> RUN else IDLE.
REQ-022 enable deasserted outside IDLE SHALL NOT abort; current app completes, then IDLE.
REQ-023 net_resp_valid=1 in any state other than WAIT_RESP SHALL be dropped and set stray_resp until reset.
REQ-024 app_result SHALL hold its value except on a WAIT_RESP capture.
REQ-025 At most one request outstanding at any time.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, cur_app=0, app_runnable=0, net_req_valid=0, net_req=0, app_result=0, stray_resp=0, countdown=0, busy=0, regardless of in-flight operation.
REQ-027 After rst release, first RUN SHALL occur the cycle after the first edge with enable=1.

Structure
REQ-028 Package app_sched_pkg SHALL hold state enum and packet field offset/width localparams.
REQ-029 Countdown SHALL be sub-module sched_countdown (load, dec, last flag, CYC_WIDTH).

Verification
REQ-030 Defaults, app k request {0, 1023-k, k}, cycles 5, ready=1, resp 2 cycles after request: app 0 runnable at cycle t, net_req={0,1023,0} valid at t+6, apps strobed in order 0,1,2,3,0.
REQ-031 Write op {1,100,7}, ready held low 3 cycles: net_req stable for 4 valid cycles; no WAIT_RESP; next app strobed 2 cycles after handshake.
REQ-032 app_cycles=0 for app 1: COMPUTE lasts exactly 1 cycle; net_req_valid the cycle after RUN+1.
REQ-033 enable dropped during app 2 COMPUTE: app 2 completes, FSM in IDLE, cur_app=3, no further strobes; re-enable -> app 3 strobed.
REQ-034 net_resp_valid pulsed in COMPUTE: stray_resp=1, app_result unchanged; rst=0 in WAIT_RESP: all outputs at reset values same cycle.
